if_id_stage: RTL



---
 rtl/mips_pkg.sv | 35 +++
 rtl/imm_extender.sv | 14 +
 rtl/if_id_stage.sv | 86 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, instruction field positions, extension modes and the IF/ID entry layout
package mips_pkg;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int TARGET_LSB = 0;
  localparam int IMM_LSB    = 0;
  typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_LUI} ext_mode_t;
  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [25:0] target;
    logic [31:0] imm_ext;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
  } id_entry_t;
  // Logical immediates are zero-extended, lui shifts into the upper half, everything else sign-extends.
  function automatic ext_mode_t ext_mode_of(input logic [5:0] op);
    return (op == OP_ANDI || op == OP_ORI || op == OP_XORI) ? EXT_ZERO :
           (op == OP_LUI) ? EXT_LUI : EXT_SIGN;
  endfunction
endpackage

// File: rtl/imm_extender.sv
// imm_extender: widens a 16-bit immediate to 32 bits by sign, zero or lui placement
module imm_extender
  import mips_pkg::*;
(
  input  logic [15:0] imm,
  input  ext_mode_t   mode,
  output logic [31:0] ext
);
  // Pure mux over the three placement rules.
  always_comb
    ext = (mode == EXT_ZERO) ? {16'h0000, imm} :
          (mode == EXT_LUI)  ? {imm, 16'h0000} :
                               {{16{imm[15]}}, imm};
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: registered fetch-to-decode boundary with a two-entry skid buffer and flush
module if_id_stage
  import mips_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int IMM_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PC_WIDTH-1:0] in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [5:0]          out_opcode,
  output logic [4:0]          out_rs,
  output logic [4:0]          out_rt,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_shamt,
  output logic [5:0]          out_funct,
  output logic [25:0]         out_target,
  output logic [31:0]         out_imm_ext,
  output logic [31:0]         out_pc_plus4,
  output logic [31:0]         out_branch_target
);
  id_entry_t   in_entry, main_q, skid_q;
  ext_mode_t   mode;
  logic        main_valid, skid_valid, accept, main_free;
  logic [31:0] imm_ext, pc_plus4;
  logic [15:0] imm;
  assign imm       = in_instr[IMM_LSB +: IMM_WIDTH];
  assign mode      = ext_mode_of(in_instr[OPCODE_LSB +: 6]);
  assign pc_plus4  = in_pc + 32'd4;
  imm_extender u_ext (.imm(imm), .mode(mode), .ext(imm_ext));
  // Decode everything on the input side so the stored entry is ready to drive decode directly.
  always_comb
    in_entry = '{
      opcode:        in_instr[OPCODE_LSB +: 6],
      rs:            in_instr[RS_LSB +: 5],
      rt:            in_instr[RT_LSB +: 5],
      rd:            in_instr[RD_LSB +: 5],
      shamt:         in_instr[SHAMT_LSB +: 5],
      funct:         in_instr[FUNCT_LSB +: 6],
      target:        in_instr[TARGET_LSB +: 26],
      imm_ext:       imm_ext,
      pc_plus4:      pc_plus4,
      branch_target: pc_plus4 + {{14{imm[15]}}, imm, 2'b00}
    };
  // in_ready depends only on skid occupancy, so out_ready never reaches it combinationally.
  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign main_free = !main_valid || out_ready;
  assign out_valid         = main_valid;
  assign out_opcode        = main_q.opcode;
  assign out_rs            = main_q.rs;
  assign out_rt            = main_q.rt;
  assign out_rd            = main_q.rd;
  assign out_shamt         = main_q.shamt;
  assign out_funct         = main_q.funct;
  assign out_target        = main_q.target;
  assign out_imm_ext       = main_q.imm_ext;
  assign out_pc_plus4      = main_q.pc_plus4;
  assign out_branch_target = main_q.branch_target;
  // Main/skid update: flush squashes both, a free main takes skid first, a held main parks the new entry in skid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      main_valid <= skid_valid || accept;
      skid_valid <= 1'b0;
      if (skid_valid) main_q <= skid_q;
      else if (accept) main_q <= in_entry;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_q     <= in_entry;
    end
  end
endmodule
